// File: rtl/mod_seq_checker_pkg.sv
// Shared definitions for the mod-N sequence checker: state encodings, default
// parameters and the modulo successor function.
package mod_seq_checker_pkg;

  typedef enum logic [1:0] {
    StSearch  = 2'd0,
    StAcquire = 2'd1,
    StLocked  = 2'd2,
    StHold    = 2'd3
  } state_e;

  localparam int unsigned DefMod     = 6;
  localparam int unsigned DefLockCnt = 3;
  localparam int unsigned DefLossCnt = 2;

  // Successor in a mod-N count; mod_last is N-1.
  function automatic logic [2:0] next_val(input logic [2:0] v, input logic [2:0] mod_last);
    return (v == mod_last) ? 3'd0 : v + 3'd1;
  endfunction

endpackage

// File: rtl/mod_seq_checker_sat_counter.sv
// Increment-enable counter that sticks at all-ones; synchronous active-high reset.
module sat_counter #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [Width-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + Width'(1);
    end
  end

endmodule

// File: rtl/mod_seq_checker.sv
// Checks that a 3-bit count stream advances 0..MOD-1 one step per valid sample,
// with lock acquisition, flywheel tracking and error/wrap reporting.
module mod_seq_checker
  import mod_seq_checker_pkg::*;
#(
  parameter int unsigned MOD      = DefMod,
  parameter int unsigned LOCK_CNT = DefLockCnt,
  parameter int unsigned LOSS_CNT = DefLossCnt,
  parameter int unsigned ERRW     = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [2:0]      din,
  input  logic            din_valid,
  output logic            locked,
  output logic            err,
  output logic [ERRW-1:0] err_count,
  output logic            wrap,
  output logic [2:0]      expected
);

  localparam int unsigned     RunW     = $clog2(LOCK_CNT + 1);
  localparam int unsigned     MissW    = $clog2(LOSS_CNT + 1);
  localparam logic [2:0]      ModLast  = 3'(MOD - 1);
  localparam logic [RunW-1:0] RunLast  = RunW'(LOCK_CNT - 1);
  localparam logic [MissW-1:0] MissLast = MissW'(LOSS_CNT - 1);

  state_e           state_q;
  logic [RunW-1:0]  run_q;
  logic [MissW-1:0] miss_q;

  logic in_range, match, tracking, miss_hit;

  assign in_range = (din <= ModLast);
  assign match    = (din == expected);
  assign tracking = (state_q == StLocked) || (state_q == StHold);
  assign miss_hit = din_valid && tracking && !match;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StSearch;
      run_q    <= '0;
      miss_q   <= '0;
      expected <= 3'd0;
      locked   <= 1'b0;
      err      <= 1'b0;
      wrap     <= 1'b0;
    end else begin
      err  <= 1'b0;
      wrap <= 1'b0;
      if (din_valid) begin
        unique case (state_q)
          StSearch: begin
            if (in_range) begin
              expected <= next_val(din, ModLast);
              run_q    <= RunW'(1);
              state_q  <= StAcquire;
            end
          end
          StAcquire: begin
            if (match) begin
              expected <= next_val(din, ModLast);
              run_q    <= run_q + RunW'(1);
              if (run_q == RunLast) begin
                state_q <= StLocked;
                locked  <= 1'b1;
              end
            end else if (in_range) begin
              expected <= next_val(din, ModLast);
              run_q    <= RunW'(1);
            end else begin
              run_q   <= '0;
              state_q <= StSearch;
            end
          end
          StLocked, StHold: begin
            // Flywheel: expected advances whether or not the sample matched.
            expected <= next_val(expected, ModLast);
            if (match) begin
              wrap    <= (din == 3'd0);
              miss_q  <= '0;
              state_q <= StLocked;
            end else begin
              err <= 1'b1;
              if ((state_q == StLocked && LOSS_CNT == 1) ||
                  (state_q == StHold && miss_q == MissLast)) begin
                state_q <= StSearch;
                locked  <= 1'b0;
                run_q   <= '0;
                miss_q  <= '0;
              end else begin
                miss_q  <= miss_q + MissW'(1);
                state_q <= StHold;
              end
            end
          end
        endcase
      end
    end
  end

  sat_counter #(
    .Width(ERRW)
  ) u_err_count (
    .clk  (clk),
    .reset(reset),
    .inc  (miss_hit),
    .count(err_count)
  );

endmodule

// File: tb/tb_mod_seq_checker.sv
// Scoreboard bench: the driver queues hand-computed responses, a monitor
// compares them one cycle after each stimulus edge.
module tb_mod_seq_checker;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] din = 3'd0;
  logic       din_valid = 1'b0;

  logic       locked, err, wrap;
  logic [7:0] err_count;
  logic [2:0] expected;

  logic       locked2, err2, wrap2;
  logic [1:0] err_count2;
  logic [2:0] expected2;

  always #5 clk = ~clk;

  mod_seq_checker #(
    .MOD(6), .LOCK_CNT(3), .LOSS_CNT(2), .ERRW(8)
  ) dut (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .locked(locked), .err(err), .err_count(err_count), .wrap(wrap), .expected(expected)
  );

  // Narrow error counter to exercise saturation on the same stimulus.
  mod_seq_checker #(
    .MOD(6), .LOCK_CNT(3), .LOSS_CNT(2), .ERRW(2)
  ) dut2 (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .locked(locked2), .err(err2), .err_count(err_count2), .wrap(wrap2), .expected(expected2)
  );

  typedef struct {
    int         due;
    int         step;
    logic       l;
    logic       e;
    logic       w;
    logic [7:0] ec;
    logic [1:0] ec2;
    logic [2:0] x;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   step_no = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every queued expectation whose cycle has arrived.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      exp_t       t;
      logic [16:0] act, req;
      t   = q.pop_front();
      act = {locked, err, wrap, err_count, err_count2, err2};
      req = {t.l, t.e, t.w, t.ec, t.ec2, t.e};
      n_cmp++;
      if (act != req || expected != t.x) begin
        n_bad++;
        $display("FAIL step%0d: got locked=%b err=%b wrap=%b cnt=%0d cnt2=%0d err2=%b exp=%0d, want locked=%b err=%b wrap=%b cnt=%0d cnt2=%0d err2=%b exp=%0d",
                 t.step, locked, err, wrap, err_count, err_count2, err2, expected,
                 t.l, t.e, t.w, t.ec, t.ec2, t.e, t.x);
      end
    end
  end

  task automatic vec(input logic r, input logic v, input logic [2:0] d,
                     input logic l, input logic e, input logic w,
                     input int ec, input logic [2:0] x);
    exp_t t;
    @(negedge clk);
    reset     = r;
    din_valid = v;
    din       = d;
    step_no++;
    t.due  = cyc + 1;
    t.step = step_no;
    t.l    = l;
    t.e    = e;
    t.w    = w;
    t.ec   = 8'(ec);
    t.ec2  = (ec > 3) ? 2'd3 : 2'(ec);
    t.x    = x;
    q.push_back(t);
  endtask

  initial begin
    //  rst v  din  L  E  W  cnt exp
    vec(1, 0, 0,   0, 0, 0, 0, 0);   // reset state
    vec(0, 1, 0,   0, 0, 0, 0, 1);   // seed
    vec(0, 1, 1,   0, 0, 0, 0, 2);
    vec(0, 1, 2,   1, 0, 0, 0, 3);   // lock on third sample
    vec(0, 1, 3,   1, 0, 0, 0, 4);
    vec(0, 1, 4,   1, 0, 0, 0, 5);
    vec(0, 1, 5,   1, 0, 0, 0, 0);
    vec(0, 1, 0,   1, 0, 1, 0, 1);   // wrap
    vec(0, 1, 3,   1, 1, 0, 1, 2);   // first miss -> hold
    vec(0, 1, 3,   0, 1, 0, 2, 3);   // second miss -> search
    vec(0, 1, 4,   0, 0, 0, 2, 5);
    vec(0, 1, 5,   0, 0, 0, 2, 0);
    vec(0, 1, 0,   1, 0, 0, 2, 1);   // locked via acquire, no wrap
    vec(0, 1, 4,   1, 1, 0, 3, 2);   // isolated miss
    vec(0, 1, 2,   1, 0, 0, 3, 3);   // recover to locked
    vec(0, 1, 7,   1, 1, 0, 4, 4);   // out-of-range miss
    vec(0, 1, 7,   0, 1, 0, 5, 5);   // lock lost; narrow counter holds at 3
    vec(0, 1, 7,   0, 0, 0, 5, 5);   // ignored in search
    vec(0, 0, 2,   0, 0, 0, 5, 5);   // gap
    vec(0, 1, 6,   0, 0, 0, 5, 5);   // ignored in search
    vec(0, 0, 1,   0, 0, 0, 5, 5);
    vec(0, 1, 2,   0, 0, 0, 5, 3);
    vec(0, 0, 0,   0, 0, 0, 5, 3);
    vec(0, 1, 3,   0, 0, 0, 5, 4);
    vec(0, 0, 6,   0, 0, 0, 5, 4);
    vec(0, 1, 4,   1, 0, 0, 5, 5);   // lock across gaps
    vec(0, 0, 1,   1, 0, 0, 5, 5);
    vec(1, 1, 5,   0, 0, 0, 0, 0);   // reset beats valid, discards lock
    vec(0, 1, 0,   0, 0, 0, 0, 1);
    vec(0, 1, 3,   0, 0, 0, 0, 4);   // reseed in acquire
    vec(0, 1, 4,   0, 0, 0, 0, 5);
    vec(0, 1, 5,   1, 0, 0, 0, 0);
    vec(0, 1, 0,   1, 0, 1, 0, 1);
    vec(0, 0, 0,   1, 0, 0, 0, 1);   // wrap returns low on gap
    vec(0, 1, 6,   1, 1, 0, 1, 2);
    vec(0, 1, 2,   1, 0, 0, 1, 3);   // hold back to locked, back-to-back valid

    @(negedge clk);
    din_valid = 1'b0;
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
